// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C master among N_REQ clients, sequencing
// start pulse, address byte and write byte, and returning done/err/read data.
module i2c_txn_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 1024,
  parameter int GAP     = 40
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] req_addr_i,
  input  logic [8*N_REQ-1:0] req_wdata_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   done_o,
  output logic [N_REQ-1:0]   err_o,
  output logic [7:0]         rdata_o,
  output logic               m_start_o,
  output logic [7:0]         m_data_o,
  input  logic               m_busy_i,
  input  logic               m_addr_ack_i,
  input  logic               m_nack_i,
  input  logic               m_done_i,
  input  logic [7:0]         m_rx_data_i
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_WAIT  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [7:0]       rdata_q, rdata_d, m_data_q, m_data_d, addr_q, addr_d, wdata_q, wdata_d;
  logic             m_start_q, m_start_d;
  logic [IW-1:0]    ptr_q, ptr_d, owner_q, owner_d, ptr_next_s, pick_idx_s;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             pick_found_s, fin_ok_s, fin_err_s;
  logic [7:0]       addr_arr_s  [N_REQ];
  logic [7:0]       wdata_arr_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr_s[g]  = req_addr_i[8*g +: 8];
    assign wdata_arr_s[g] = req_wdata_i[8*g +: 8];
  end

  assign ptr_next_s = (owner_q == IW'(N_REQ - 1)) ? {IW{1'b0}} : owner_q + IW'(1);

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned idx_w;
    logic [IW-1:0] idx_s;
    idx_w        = 0;
    idx_s        = {IW{1'b0}};
    pick_found_s = 1'b0;
    pick_idx_s   = {IW{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      idx_w        = (int'(ptr_q) + k) % N_REQ;
      idx_s        = IW'(idx_w);
      pick_idx_s   = (req_i[idx_s] && !pick_found_s) ? idx_s : pick_idx_s;
      pick_found_s = pick_found_s | req_i[idx_s];
    end
  end

  // Next-state and output decode for the transaction sequencer.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = {N_REQ{1'b0}};
    err_d     = {N_REQ{1'b0}};
    rdata_d   = rdata_q;
    m_start_d = 1'b0;
    m_data_d  = m_data_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    fin_ok_s  = 1'b0;
    fin_err_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found_s && !m_busy_i) begin
          owner_d   = pick_idx_s;
          addr_d    = addr_arr_s[pick_idx_s];
          wdata_d   = wdata_arr_s[pick_idx_s];
          gnt_d     = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
          m_start_d = 1'b1;
          m_data_d  = addr_arr_s[pick_idx_s];
          state_d   = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        tmo_d   = {TW{1'b0}};
        state_d = S_ADDR;
      end
      S_ADDR: begin
        if (m_nack_i) begin
          fin_err_s = 1'b1;
        end else if (m_addr_ack_i) begin
          tmo_d    = {TW{1'b0}};
          state_d  = addr_q[0] ? S_WAIT : S_DATA;
          m_data_d = addr_q[0] ? addr_q : wdata_q;
        end else if (tmo_q == TMO_LAST) begin
          fin_err_s = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DATA, S_WAIT: begin
        if (m_nack_i) begin
          fin_err_s = 1'b1;
        end else if (m_done_i) begin
          fin_ok_s = 1'b1;
          rdata_d  = addr_q[0] ? m_rx_data_i : rdata_q;
        end else if (tmo_q == TMO_LAST) begin
          fin_err_s = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GAP: begin
        m_data_d = 8'h00;
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Common wrap-up: the one-hot grant doubles as the owner's pulse mask.
    if (fin_ok_s || fin_err_s) begin
      done_d   = fin_ok_s ? gnt_q : {N_REQ{1'b0}};
      err_d    = fin_err_s ? gnt_q : {N_REQ{1'b0}};
      gnt_d    = {N_REQ{1'b0}};
      ptr_d    = ptr_next_s;
      gap_d    = {GW{1'b0}};
      m_data_d = 8'h00;
      state_d  = S_GAP;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      gnt_q     <= {N_REQ{1'b0}};
      done_q    <= {N_REQ{1'b0}};
      err_q     <= {N_REQ{1'b0}};
      rdata_q   <= 8'h00;
      m_start_q <= 1'b0;
      m_data_q  <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      ptr_q     <= {IW{1'b0}};
      owner_q   <= {IW{1'b0}};
      tmo_q     <= {TW{1'b0}};
      gap_q     <= {GW{1'b0}};
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      m_start_q <= m_start_d;
      m_data_q  <= m_data_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign m_start_o = m_start_q;
  assign m_data_o  = m_data_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench for i2c_txn_arbiter (N_REQ=3, TIMEOUT=16, GAP=4).
module tb_i2c_txn_arbiter;

  localparam int N_REQ   = 3;
  localparam int TIMEOUT = 16;
  localparam int GAP     = 4;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [N_REQ-1:0]   req_i = '0;
  logic [8*N_REQ-1:0] req_addr_i = '0;
  logic [8*N_REQ-1:0] req_wdata_i = '0;
  logic [N_REQ-1:0]   gnt_o, done_o, err_o;
  logic [7:0]         rdata_o, m_data_o;
  logic               m_start_o;
  logic               m_busy_i = 1'b0;
  logic               m_addr_ack_i = 1'b0;
  logic               m_nack_i = 1'b0;
  logic               m_done_i = 1'b0;
  logic [7:0]         m_rx_data_i = 8'h00;

  int checks = 0;
  int failures = 0;
  int n;

  i2c_txn_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .m_start_o(m_start_o), .m_data_o(m_data_o),
    .m_busy_i(m_busy_i), .m_addr_ack_i(m_addr_ack_i), .m_nack_i(m_nack_i),
    .m_done_i(m_done_i), .m_rx_data_i(m_rx_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic wait_gnt(input int max_cyc, output int cyc);
    cyc = 0;
    while (gnt_o == '0 && cyc < max_cyc) begin
      tick();
      cyc++;
    end
  endtask

  task automatic pulse_ack();
    m_addr_ack_i = 1'b1;
    tick();
    m_addr_ack_i = 1'b0;
  endtask

  logic [2:0] rr_mask [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [7:0] rr_wd   [3] = '{8'h0E, 8'h11, 8'h22};

  initial begin
    repeat (3) tick();
    rst_i = 1'b0;
    chk_eq("rst_gnt", gnt_o, 0);
    chk_eq("rst_done_err", {done_o, err_o}, 0);
    chk_eq("rst_mstart", m_start_o, 0);
    chk_eq("rst_mdata", m_data_o, 8'h00);
    chk_eq("rst_rdata", rdata_o, 8'h00);

    // Write transaction from client 0
    req_i = 3'b001; req_addr_i[7:0] = 8'h3E; req_wdata_i[7:0] = 8'h0E;
    tick();
    chk_eq("wr_gnt", gnt_o, 3'b001);
    chk_eq("wr_start", m_start_o, 1);
    chk_eq("wr_addr_byte", m_data_o, 8'h3E);
    tick();
    chk_eq("wr_start_1cyc", m_start_o, 0);
    chk_eq("wr_addr_hold", m_data_o, 8'h3E);
    pulse_ack();
    chk_eq("wr_data_byte", m_data_o, 8'h0E);
    chk_eq("wr_gnt_held", gnt_o, 3'b001);
    m_done_i = 1'b1;
    tick();
    m_done_i = 1'b0;
    chk_eq("wr_done", done_o, 3'b001);
    chk_eq("wr_no_err", err_o, 0);
    chk_eq("wr_gnt_drop", gnt_o, 0);
    chk_eq("wr_gap_mdata", m_data_o, 8'h00);

    // Read transaction from client 0, requested during the gap
    req_addr_i[7:0] = 8'h3F;
    tick();
    chk_eq("wr_done_1cyc", done_o, 0);
    wait_gnt(20, n);
    chk_eq("gap_len", n, GAP);
    chk_eq("rd_gnt", gnt_o, 3'b001);
    chk_eq("rd_addr_byte", m_data_o, 8'h3F);
    tick();
    pulse_ack();
    chk_eq("rd_wait_mdata", m_data_o, 8'h3F);
    m_done_i = 1'b1; m_rx_data_i = 8'h0E;
    tick();
    m_done_i = 1'b0; req_i = 3'b000;
    chk_eq("rd_done", done_o, 3'b001);
    chk_eq("rd_rdata", rdata_o, 8'h0E);

    // Bad address: NACK in ADDR from client 1
    req_i = 3'b010; req_addr_i[15:8] = 8'hC7;
    wait_gnt(20, n);
    chk_eq("gap_len2", n, GAP + 1);
    chk_eq("nack_gnt", gnt_o, 3'b010);
    tick();
    m_nack_i = 1'b1;
    tick();
    m_nack_i = 1'b0; req_i = 3'b000;
    chk_eq("nack_err", err_o, 3'b010);
    chk_eq("nack_no_done", done_o, 0);
    chk_eq("nack_rdata", rdata_o, 8'h0E);

    // Timeout in ADDR from client 2
    req_i = 3'b100; req_addr_i[23:16] = 8'hA0;
    wait_gnt(20, n);
    chk_eq("tmo_gnt", gnt_o, 3'b100);
    tick();
    repeat (TIMEOUT - 1) tick();
    chk_eq("tmo_not_yet", err_o, 0);
    tick();
    req_i = 3'b000;
    chk_eq("tmo_err", err_o, 3'b100);
    chk_eq("tmo_gnt_drop", gnt_o, 0);

    // NACK and done together: error only
    req_i = 3'b001; req_addr_i[7:0] = 8'h3F;
    wait_gnt(20, n);
    chk_eq("prio_gnt", gnt_o, 3'b001);
    tick();
    pulse_ack();
    m_nack_i = 1'b1; m_done_i = 1'b1; m_rx_data_i = 8'h55;
    tick();
    m_nack_i = 1'b0; m_done_i = 1'b0; req_i = 3'b000;
    chk_eq("prio_err", err_o, 3'b001);
    chk_eq("prio_no_done", done_o, 0);
    chk_eq("prio_rdata", rdata_o, 8'h0E);

    // Reset during DATA
    req_i = 3'b010; req_addr_i[15:8] = 8'h3E; req_wdata_i[15:8] = 8'h0E;
    wait_gnt(20, n);
    chk_eq("rstd_gnt", gnt_o, 3'b010);
    tick();
    pulse_ack();
    chk_eq("rstd_data", m_data_o, 8'h0E);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_eq("rstd_gnt0", gnt_o, 0);
    chk_eq("rstd_pulses", {done_o, err_o}, 0);
    chk_eq("rstd_mdata", m_data_o, 8'h00);
    chk_eq("rstd_rdata", rdata_o, 8'h00);

    // Round-robin with all requests held, restarting at client 0
    req_i = 3'b111;
    req_addr_i = {8'hA0, 8'h3E, 8'h3E};
    req_wdata_i = {rr_wd[2], rr_wd[1], rr_wd[0]};
    for (int i = 0; i < 4; i++) begin
      wait_gnt(20, n);
      chk_eq($sformatf("rr_wait%0d", i), n, (i == 0) ? 1 : GAP + 1);
      chk_eq($sformatf("rr_gnt%0d", i), gnt_o, rr_mask[i]);
      tick();
      pulse_ack();
      chk_eq($sformatf("rr_wdata%0d", i), m_data_o, rr_wd[i % 3]);
      m_done_i = 1'b1;
      tick();
      m_done_i = 1'b0;
      chk_eq($sformatf("rr_done%0d", i), done_o, rr_mask[i]);
    end
    req_i = 3'b000;

    // Master busy blocks the grant
    req_i = 3'b010; m_busy_i = 1'b1;
    repeat (10) tick();
    chk_eq("busy_no_gnt", gnt_o, 0);
    m_busy_i = 1'b0;
    tick();
    chk_eq("busy_release_gnt", gnt_o, 3'b010);
    chk_eq("busy_release_start", m_start_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
